wb_pwm: RTL and testbench

//   Multi-channel PWM generator; Wishbone slave on a free conbus slave slot (e.g. 0x70000000).

---
 rtl/wb_pwm.sv | 121 ++++++++++++
 tb/tb_wb_pwm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pwm.sv
// wb_pwm: Wishbone multi-channel PWM with double-buffered duty compares and a period-wrap interrupt
module wb_pwm #(
    parameter int channels  = 4,
    parameter int cnt_width = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    output logic [31:0]         wb_dat_o,
    input  logic [3:0]          wb_sel_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    input  logic                wb_we_i,
    output logic                wb_ack_o,
    output logic                intr,
    output logic [channels-1:0] pwm_o
);
    typedef logic [cnt_width-1:0] cnt_t;

    logic [3:0]          off;
    logic                req, wr, clr, wrap_evt, load, adr_unused;
    logic                ack_q, ack_d, en_q, en_d, irq_en_q, irq_en_d;
    logic                inv_q, inv_d, wrap_q, wrap_d;
    logic [31:0]         dat_q, dat_d, rdata;
    cnt_t                period_q, period_d, count_q, count_d;
    cnt_t                duty_sh_q  [channels];
    cnt_t                duty_sh_d  [channels];
    cnt_t                duty_act_q [channels];
    cnt_t                duty_act_d [channels];
    logic [channels-1:0] pwm_q, pwm_d;

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    assign adr_unused = ^{wb_adr_i[31:6], wb_adr_i[1:0]};
    assign off        = wb_adr_i[5:2];
    assign req        = wb_stb_i & wb_cyc_i;
    assign wr         = req & wb_we_i & ack_q;
    assign clr        = wr && off == 4'd2 && wb_sel_i[0] && wb_dat_i[0];
    assign wrap_evt   = en_q && count_q >= period_q;
    assign load       = !en_q || wrap_evt;
    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign intr       = irq_en_q & wrap_q;
    assign pwm_o      = pwm_q;

    // Register image selected by word offset, zero-extended; unmapped offsets read 0
    always_comb begin
        rdata = 32'b0;
        if (off == 4'd0) rdata = {29'b0, inv_q, irq_en_q, en_q};
        if (off == 4'd1) rdata = 32'(period_q);
        if (off == 4'd2) rdata = {31'b0, wrap_q};
        if (off == 4'd3) rdata = 32'(count_q);
        for (int i = 0; i < channels; i++)
            if (int'(off) == 4 + i) rdata = 32'(duty_sh_q[i]);
    end

    // Single-pulse ack with data, and byte-lane register writes committed on the ack cycle
    always_comb begin
        ack_d    = req & ~ack_q;
        dat_d    = (req & ~ack_q) ? rdata : 32'b0;
        en_d     = (wr && off == 4'd0 && wb_sel_i[0]) ? wb_dat_i[0] : en_q;
        irq_en_d = (wr && off == 4'd0 && wb_sel_i[0]) ? wb_dat_i[1] : irq_en_q;
        inv_d    = (wr && off == 4'd0 && wb_sel_i[0]) ? wb_dat_i[2] : inv_q;
        period_d = (wr && off == 4'd1) ? cnt_t'(lanes(32'(period_q), wb_dat_i, wb_sel_i)) : period_q;
        for (int i = 0; i < channels; i++)
            duty_sh_d[i] = (wr && int'(off) == 4 + i) ? cnt_t'(lanes(32'(duty_sh_q[i]), wb_dat_i, wb_sel_i)) : duty_sh_q[i];
    end

    // Counter wrap, shadow-to-active duty reload, sticky wrap flag (set beats clear)
    always_comb begin
        count_d = load ? '0 : count_q + 1'b1;
        wrap_d  = wrap_evt | (wrap_q & ~clr);
        for (int i = 0; i < channels; i++)
            duty_act_d[i] = load ? duty_sh_q[i] : duty_act_q[i];
    end

    // Duty compare per channel, polarity applied before the output register
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < channels; i++)
            pwm_d[i] = inv_q ^ (en_q & (count_q < duty_act_q[i]));
    end

    // State registers with synchronous reset taking priority over any bus activity
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'b0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            inv_q    <= 1'b0;
            wrap_q   <= 1'b0;
            period_q <= '0;
            count_q  <= '0;
            pwm_q    <= '0;
            for (int i = 0; i < channels; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            inv_q    <= inv_d;
            wrap_q   <= wrap_d;
            period_q <= period_d;
            count_q  <= count_d;
            pwm_q    <= pwm_d;
            for (int i = 0; i < channels; i++) begin
                duty_sh_q[i]  <= duty_sh_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end
endmodule

// File: tb/tb_wb_pwm.sv
// tb_wb_pwm: register vector table, random PWM runs against an arithmetic model, and timed corner sequences
module tb_wb_pwm;
    localparam int CH = 4;
    localparam logic [31:0] BASE = 32'h7000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   wb_adr_i = 32'b0, wb_dat_i = 32'b0, wb_dat_o;
    logic [3:0]    wb_sel_i = 4'b0;
    logic          wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o, intr;
    logic [CH-1:0] pwm_o;

    int errors = 0;
    int checks = 0;
    int dty [CH];
    logic [CH-1:0] hist [8192];
    int ncyc = 0;

    typedef struct {
        logic        we;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] e;
    } vec_t;
    vec_t tv [$];

    wb_pwm #(.channels(CH), .cnt_width(16)) dut (
        .clk(clk), .reset(reset),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
        .intr(intr), .pwm_o(pwm_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        hist[ncyc % 8192] <= pwm_o;
        ncyc <= ncyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, output logic [31:0] rd);
        @(negedge clk);
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        chk("ack_low_at_request", 32'(wb_ack_o), 32'd0);
        @(negedge clk);
        chk("ack_one_cycle_after", 32'(wb_ack_o), 32'd1);
        rd = wb_dat_o;
        @(negedge clk);
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        chk("ack_single_pulse", 32'(wb_ack_o), 32'd0);
    endtask

    task automatic add(input logic we, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic [31:0] e);
        vec_t v;
        v.we = we; v.a = a; v.d = d; v.s = s; v.e = e;
        tv.push_back(v);
    endtask

    task automatic setup(input int p, input logic [31:0] ctrl);
        logic [31:0] rd;
        bus(1'b1, BASE + 32'h00, 32'd0, 4'hF, rd);
        bus(1'b1, BASE + 32'h08, 32'd1, 4'hF, rd);
        bus(1'b1, BASE + 32'h04, 32'(p), 4'hF, rd);
        for (int i = 0; i < CH; i++) bus(1'b1, BASE + 32'h10 + 32'(4 * i), 32'(dty[i]), 4'hF, rd);
        bus(1'b1, BASE + 32'h00, ctrl, 4'hF, rd);
    endtask

    task automatic run_model(input int p, input bit inv, input bit irq, input int n);
        logic [CH-1:0] e;
        setup(p, {29'b0, inv, irq, 1'b1});
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) e[i] = inv ^ ((k % (p + 1)) < dty[i]);
            chk("pwm_model", 32'(pwm_o), 32'(e));
            chk("intr_model", 32'(intr), 32'(irq && k >= p));
        end
    endtask

    initial begin
        logic [31:0] rd;
        int base, h0, h1, p;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", 32'(wb_ack_o), 32'd0);
        chk("reset_dat", wb_dat_o, 32'd0);
        chk("reset_pwm", 32'(pwm_o), 32'd0);
        chk("reset_intr", 32'(intr), 32'd0);
        reset = 1'b0;

        for (int a = 0; a < 8; a++) add(1'b0, 8'(4 * a), 32'd0, 4'hF, 32'd0);
        add(1'b0, 8'h20, 32'd0, 4'hF, 32'd0);
        add(1'b0, 8'h3C, 32'd0, 4'hF, 32'd0);
        add(1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, 32'd0);
        add(1'b0, 8'h04, 32'd0, 4'hF, 32'h0000_FFFF);
        add(1'b1, 8'h04, 32'h0000_AB12, 4'h1, 32'd0);
        add(1'b0, 8'h04, 32'd0, 4'hF, 32'h0000_FF12);
        add(1'b1, 8'h04, 32'h00CD_0000, 4'h4, 32'd0);
        add(1'b0, 8'h04, 32'd0, 4'hF, 32'h0000_FF12);
        add(1'b1, 8'h18, 32'h1234_5678, 4'hC, 32'd0);
        add(1'b0, 8'h18, 32'd0, 4'hF, 32'd0);
        add(1'b1, 8'h18, 32'h0000_5678, 4'h2, 32'd0);
        add(1'b0, 8'h18, 32'd0, 4'hF, 32'h0000_5600);
        add(1'b1, 8'h1C, 32'h0000_BEEF, 4'h3, 32'd0);
        add(1'b0, 8'h1C, 32'd0, 4'hF, 32'h0000_BEEF);
        add(1'b1, 8'h3C, 32'hFFFF_FFFF, 4'hF, 32'd0);
        add(1'b0, 8'h3C, 32'd0, 4'hF, 32'd0);
        add(1'b1, 8'h0C, 32'd5, 4'hF, 32'd0);
        add(1'b0, 8'h0C, 32'd0, 4'hF, 32'd0);
        add(1'b1, 8'h08, 32'd1, 4'hF, 32'd0);
        add(1'b0, 8'h08, 32'd0, 4'hF, 32'd0);
        add(1'b1, 8'h00, 32'h0000_00FE, 4'hF, 32'd0);
        add(1'b0, 8'h00, 32'd0, 4'hF, 32'd6);
        add(1'b1, 8'h00, 32'h0000_0001, 4'hE, 32'd0);
        add(1'b0, 8'h00, 32'd0, 4'hF, 32'd6);
        add(1'b1, 8'h00, 32'h0000_0000, 4'h1, 32'd0);
        add(1'b0, 8'h00, 32'd0, 4'hF, 32'd0);
        foreach (tv[v]) begin
            bus(tv[v].we, BASE + 32'(tv[v].a), tv[v].d, tv[v].s, rd);
            if (!tv[v].we) chk($sformatf("reg_rd_%0h", tv[v].a), rd, tv[v].e);
        end

        dty = '{3, 0, 0, 0};
        run_model(9, 1'b0, 1'b1, 30);
        dty = '{0, 10, 5, 2};
        run_model(9, 1'b0, 1'b0, 25);
        run_model(9, 1'b1, 1'b0, 25);

        for (int r = 0; r < 6; r++) begin
            p = int'($urandom_range(15, 0));
            for (int i = 0; i < CH; i++) dty[i] = int'($urandom_range(p + 2, 0));
            run_model(p, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 2 * (p + 1) + 3);
        end

        dty = '{3, 0, 0, 0};
        setup(9, 32'd1);
        #1 base = ncyc;
        skip(2);
        bus(1'b1, BASE + 32'h10, 32'd7, 4'hF, rd);
        skip(16);
        #1;
        h0 = 0;
        h1 = 0;
        for (int k = 0; k < 10; k++) begin
            h0 += int'(hist[(base + k) % 8192][0]);
            h1 += int'(hist[(base + 10 + k) % 8192][0]);
        end
        chk("duty_old_period_highs", 32'(h0), 32'd3);
        chk("duty_new_period_highs", 32'(h1), 32'd7);

        dty = '{3, 0, 0, 0};
        setup(9, 32'd3);
        skip(9);
        chk("intr_before_wrap", 32'(intr), 32'd0);
        skip(1);
        chk("intr_at_wrap", 32'(intr), 32'd1);
        bus(1'b1, BASE + 32'h08, 32'd1, 4'hF, rd);
        chk("intr_cleared", 32'(intr), 32'd0);
        skip(4);
        bus(1'b1, BASE + 32'h08, 32'd1, 4'hF, rd);
        chk("intr_set_wins_clear", 32'(intr), 32'd1);
        bus(1'b1, BASE + 32'h08, 32'd1, 4'hF, rd);
        chk("intr_cleared_again", 32'(intr), 32'd0);

        setup(9, 32'd3);
        skip(5);
        bus(1'b1, BASE + 32'h04, 32'd4, 4'hF, rd);
        chk("no_wrap_yet", 32'(intr), 32'd0);
        bus(1'b0, BASE + 32'h0C, 32'd0, 4'hF, rd);
        chk("count_after_short_period", rd, 32'd0);
        chk("wrap_after_short_period", 32'(intr), 32'd1);

        @(negedge clk);
        wb_adr_i = BASE;
        wb_dat_i = 32'd7;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b1;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        @(negedge clk);
        chk("ack_before_reset", 32'(wb_ack_o), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_ack", 32'(wb_ack_o), 32'd0);
        chk("midreset_dat", wb_dat_o, 32'd0);
        chk("midreset_pwm", 32'(pwm_o), 32'd0);
        chk("midreset_intr", 32'(intr), 32'd0);
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus(1'b0, BASE + 32'(4 * a), 32'd0, 4'hF, rd);
            chk($sformatf("post_reset_rd_%0d", a), rd, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
